// File: rtl/vip_stream_output_stage_if.sv
// Avalon-ST style word stream (valid/ready/data/sop/eop) used on both sides of
// the video output stage; master drives the payload, slave drives ready.
interface vip_stream_output_stage_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (output valid, output data, output sop, output eop, input ready);
  modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/vip_stream_output_stage.sv
// Avalon-ST output stage: 4-entry FIFO from a ready-latency-0 internal stream to a
// ready-latency-1 dout stream, gated to whole packets. Option: STREAM_OUT_DISCARD_EN.
module vip_stream_output_stage #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        synced,
  vip_stream_output_stage_if.slave    int_if,
  vip_stream_output_stage_if.master   dout_if
);

  localparam int DEPTH = 4;

  typedef enum logic {ST_STOPPED, ST_RUNNING} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } word_t;

  word_t       mem_q [DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  state_e      state_q, state_d;
  logic        int_ready_q, int_ready_d;
  logic        synced_q, synced_d;
  logic        dout_valid_q, dout_valid_d;
  word_t       dout_q, dout_d;

  logic        push, pop, send, not_empty;
  logic        head_eligible, head_discard;
  word_t       head;

  assign push      = int_if.valid & int_ready_q;
  assign not_empty = (count_q != 3'd0);
  assign head      = mem_q[rd_ptr_q];

  // Head policy: in RUNNING everything goes out; in STOPPED only a sop may
  // start output, and mid-packet words are dropped to resynchronise.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_eligible = 1'b0;
    head_discard  = 1'b0;
    if (state_q == ST_RUNNING) begin
      head_eligible = 1'b1;
    end else if (!head.sop) begin
      head_discard = 1'b1;
    end else if (enable) begin
      head_eligible = 1'b1;
    end
`ifdef STREAM_OUT_DISCARD_EN
    else begin
      head_discard = 1'b1;
    end
`endif
  end

  assign send = not_empty & head_eligible & dout_if.ready;
  assign pop  = send | (not_empty & head_discard);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (send)                       state_d = ST_RUNNING;
      ST_RUNNING: if (send && head.eop && !enable) state_d = ST_STOPPED;
      default:                                     state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {1'b0, push};
    rd_ptr_d     = rd_ptr_q + {1'b0, pop};
    count_d      = count_q + {2'b00, push} - {2'b00, pop};
    int_ready_d  = (count_d != 3'(DEPTH));
    synced_d     = (state_d == ST_RUNNING);
    dout_valid_d = send;
    dout_d       = send ? head : dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_STOPPED;
      int_ready_q  <= 1'b0;
      synced_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      int_ready_q  <= int_ready_d;
      synced_q     <= synced_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: int_if.data, sop: int_if.sop, eop: int_if.eop};
  end

  assign int_if.ready  = int_ready_q;
  assign synced        = synced_q;
  assign dout_if.valid = dout_valid_q;
  assign dout_if.data  = dout_q.data;
  assign dout_if.sop   = dout_q.sop;
  assign dout_if.eop   = dout_q.eop;

endmodule

// File: tb/tb_vip_stream_output_stage.sv
// Self-checking bench for vip_stream_output_stage: scoreboard of expected dout
// words plus per-scenario timing checks. Honors STREAM_OUT_DISCARD_EN.
module tb_vip_stream_output_stage;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic synced;

  vip_stream_output_stage_if #(.DATA_WIDTH(DW)) int_if ();
  vip_stream_output_stage_if #(.DATA_WIDTH(DW)) dout_if ();

  vip_stream_output_stage #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .synced  (synced),
    .int_if  (int_if),
    .dout_if (dout_if)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_accept_cyc = 0;
  int sop_cyc = 0;
  int eop_cyc = 0;
  logic sop_synced = 1'b0;
  logic prev_ready = 1'b0;
  logic [DW+1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every valid dout word is popped from the scoreboard.
  always @(negedge clk) begin
    logic [DW+1:0] got, want;
    if (dout_if.valid === 1'b1) begin
      got = {dout_if.data, dout_if.sop, dout_if.eop};
      compared++;
      if (prev_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL ready_latency: dout_valid=1 at cycle %0d but dout_ready was %b one cycle earlier", cyc, prev_ready);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_word: got data/sop/eop %h, scoreboard empty", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          mismatched++;
          $display("FAIL dout_word: got data/sop/eop %h, expected %h", got, want);
        end
      end
      if (dout_if.sop) begin sop_cyc = cyc; sop_synced = synced; end
      if (dout_if.eop) eop_cyc = cyc;
    end
    prev_ready = dout_if.ready;
  end

  task automatic push_word(input logic [DW-1:0] d, input logic s, input logic e, input bit expect_out);
    bit ok = 1'b0;
    int_if.valid = 1'b1;
    int_if.data  = d;
    int_if.sop   = s;
    int_if.eop   = e;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (int_if.ready === 1'b1) begin
        if (expect_out) exp_q.push_back({d, s, e});
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (ok) last_accept_cyc = cyc;
    int_if.valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL push_timeout: word %h not accepted within 100 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    compared += 6;
    if (dout_if.valid !== 1'b0) begin mismatched++; $display("FAIL %s_valid: got %b required 0", name, dout_if.valid); end
    if (dout_if.data !== '0)    begin mismatched++; $display("FAIL %s_data: got %h required 0", name, dout_if.data); end
    if (dout_if.sop !== 1'b0)   begin mismatched++; $display("FAIL %s_sop: got %b required 0", name, dout_if.sop); end
    if (dout_if.eop !== 1'b0)   begin mismatched++; $display("FAIL %s_eop: got %b required 0", name, dout_if.eop); end
    if (int_if.ready !== 1'b0)  begin mismatched++; $display("FAIL %s_int_ready: got %b required 0", name, int_if.ready); end
    if (synced !== 1'b0)        begin mismatched++; $display("FAIL %s_synced: got %b required 0", name, synced); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (int_if.ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_int_ready: got %b required 1", int_if.ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_resync();
    enable = 1'b1;
    dout_if.ready = 1'b1;
    push_word(10'h00A, 1'b0, 1'b0, 1'b0);
    push_word(10'h00B, 1'b0, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    compared++;
    if (synced !== 1'b0 || dout_if.valid !== 1'b0) begin
      mismatched++;
      $display("FAIL resync_discard: synced=%b dout_valid=%b required 0/0", synced, dout_if.valid);
    end
    @(posedge clk); #1;
    push_word(10'h010, 1'b1, 1'b0, 1'b1);
    push_word(10'h011, 1'b0, 1'b0, 1'b1);
    push_word(10'h012, 1'b0, 1'b1, 1'b1);
    wait_drain("resync");
    idle(2);
  endtask

  task automatic test_basic();
    int first_acc;
    enable = 1'b1;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(10'(i + 1), i == 0, i == 3, 1'b1);
      if (i == 0) first_acc = last_accept_cyc;
    end
    wait_drain("basic");
    compared += 3;
    if (sop_cyc !== first_acc + 1) begin
      mismatched++;
      $display("FAIL basic_latency: sop on dout at edge %0d, required %0d", sop_cyc, first_acc + 1);
    end
    if (eop_cyc !== sop_cyc + 3) begin
      mismatched++;
      $display("FAIL basic_throughput: eop at edge %0d, required %0d", eop_cyc, sop_cyc + 3);
    end
    if (sop_synced !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_synced: synced=%b in sop cycle, required 1", sop_synced);
    end
    idle(2);
  endtask

  task automatic test_ready_latency();
    logic pat   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dout_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(10'(32'h020 + i), i == 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      dout_if.ready = pat[i];
      @(negedge clk);
      if (i == 0) begin
        compared++;
        if (int_if.ready !== 1'b0) begin
          mismatched++;
          $display("FAIL full_int_ready: got %b with 4 entries, required 0", int_if.ready);
        end
      end
      compared++;
      if (dout_if.valid !== exp_v[i]) begin
        mismatched++;
        $display("FAIL latency_valid_%0d: got %b required %b", i, dout_if.valid, exp_v[i]);
      end
      @(posedge clk); #1;
    end
    dout_if.ready = 1'b1;
    for (int i = 4; i < 8; i++) push_word(10'(32'h020 + i), 1'b0, i == 7, 1'b1);
    wait_drain("ready_latency");
    idle(2);
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(10'(32'h030 + i), i == 0, i == 7, 1'b1);
      if (i == 1) enable = 1'b0;
    end
    wait_drain("enable_drop");
    @(negedge clk);
    compared++;
    if (synced !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_synced: got %b after eop, required 0", synced);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_word(10'(32'h040 + i), i == 0, 1'b0, 1'b0);
    @(negedge clk);
    compared++;
`ifdef STREAM_OUT_DISCARD_EN
    if (int_if.ready !== 1'b1) begin
      mismatched++;
      $display("FAIL drop_int_ready: got %b while discarding, required 1", int_if.ready);
    end
`else
    if (int_if.ready !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_int_ready: got %b with held packet, required 0", int_if.ready);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (dout_if.valid !== 1'b0 || synced !== 1'b0) begin
        mismatched++;
        $display("FAIL drop_idle_%0d: dout_valid=%b synced=%b, required 0/0", i, dout_if.valid, synced);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    dout_if.ready = 1'b0;
    push_word(10'h050, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) push_word(10'(32'h050 + i), 1'b0, i == 3, 1'b0);
    dout_if.ready = 1'b1;
    @(posedge clk); #1;
    dout_if.ready = 1'b0;
    @(negedge clk);
    compared++;
    if (dout_if.valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_pre_reset_valid: got %b required 1", dout_if.valid);
    end
    #1 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (int_if.ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_release_int_ready: got %b required 1", int_if.ready);
    end
    @(posedge clk); #1;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (dout_if.valid !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_stale_%0d: dout_valid=%b data=%h, required valid 0", i, dout_if.valid, dout_if.data);
      end
    end
    @(posedge clk); #1;
    push_word(10'h060, 1'b1, 1'b0, 1'b1);
    push_word(10'h061, 1'b0, 1'b1, 1'b1);
    wait_drain("reset_mid");
    idle(2);
  endtask

  initial begin
    int_if.valid  = 1'b0;
    int_if.data   = '0;
    int_if.sop    = 1'b0;
    int_if.eop    = 1'b0;
    dout_if.ready = 1'b0;
    test_reset();
    test_resync();
    test_basic();
    test_ready_latency();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
